switch_control: RTL and testbench
=================================

Name: switch_control

Overview:
- Per-router allocation stage that sits directly upstream of the crossbar and downstream of the five input buffers.
- Arbitrates round-robin among input ports that present a header flit and computes the XY output port from the header destination.
- Checks that the output port is free, then records the connection in the crossbar mux tables and acknowledges the header.
- Frees a connection when its source input stops sending.

Parameters:
ADDRESS, 16'h0000, local router address; [TAM_FLIT-1:METADEFLIT]=x, [METADEFLIT-1:0]=y

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_h  in  NPORT  per-input header request; held high until acked
i_data  in  NPORT*TAM_FLIT  head flit of each input buffer; port p at slice [p*TAM_FLIT +: TAM_FLIT]
i_sender  in  NPORT  per-input "still transmitting packet" flag
o_ack_h  out  NPORT  one-cycle header acknowledge, one-hot or zero
o_mux_in  out  NPORT*3  per output port p: index of the input driving it
o_mux_out  out  NPORT*3  per input port p: index of its output; 3'b111 = unconnected
o_free  out  NPORT  per-output free flag

Behaviour:
- Port indices: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
- Reset, applied on any i_clk edge with i_rst=1, including mid-operation:
  - state=S_IDLE, o_ack_h=0, o_free=5'b11111
  - o_mux_in all 0, o_mux_out all 3'b111
  - rr_ptr=LOCAL; sel, route and dest registers cleared
- FSM state transitions (one cycle each):
  - S_IDLE: |i_h -> S_ARB; else stay.
  - S_ARB: sel = first p with i_h[p]=1, searching from (rr_ptr+1) mod 5 upward with wrap. Set rr_ptr=sel. -> S_ROUTE. If i_h is all zero here (request withdrawn), -> S_IDLE without updating rr_ptr.
  - S_ROUTE: latch the route register from i_data[sel] using XY order:
    - dest_x>local_x -> EAST
    - dest_x<local_x -> WEST
    - else dest_y<local_y -> SOUTH
    - else dest_y>local_y -> NORTH
    - else LOCAL
    - Comparisons are unsigned on METADEFLIT bits. -> S_CHECK.
  - S_CHECK: o_free[route]=1 -> S_GRANT; else -> S_IDLE (retry later; rr_ptr already advanced, so other requesters get priority).
  - S_GRANT: o_ack_h[sel]=1 this cycle only (Moore decode of registered state). At the cycle-end edge: o_mux_in[route]=sel, o_mux_out[sel]=route, o_free[route]=0. -> S_IDLE.
- Latency: i_h sampled in S_IDLE at edge k gives o_ack_h high in the cycle after edge k+3, i.e. 4 cycles, when the port is free and wins arbitration.
- Release runs every cycle, independent of the FSM:
  - For each output q with o_free[q]=0 and i_sender[o_mux_in[q]]=0: o_free[q]=1 and o_mux_out[o_mux_in[q]]=3'b111 at the next edge.
  - o_mux_in[q] keeps its old value.
- Simultaneous events:
  - Release of port q and grant of a different port in the same cycle: both take effect.
  - Grant cannot target a busy port, because S_CHECK uses registered o_free. A port released in the same cycle S_CHECK sees it busy leads to a retry, not a grant.
  - i_sender of the source being granted is ignored in the S_GRANT cycle; release is evaluated from the next cycle on.
- A route to the requesting port's own direction (e.g. EAST in -> EAST out) is allowed; XY routing makes it impossible for legal traffic.
- Only one header is in flight at a time; other i_h requests wait in S_IDLE.

Decomposition:
- Constants come from shared defines.vh: TAM_FLIT=16, METADEFLIT=8, NPORT=5, EAST/WEST/NORTH/SOUTH/LOCAL indices.
- defines.vh gains: FSM state encodings S_IDLE..S_GRANT (3 bits) and PORT_NONE=3'b111.
- One sub-module: rr_arbiter5 (combinational).
  - Inputs: request vector, rr_ptr.
  - Outputs: 3-bit grant index and a valid flag.
- XY compute, FSM, mux tables and release logic stay in switch_control.

Test Plan:
1. Reset: assert i_rst 2 cycles -> o_free=5'b11111, o_ack_h=0, all o_mux_out=3'b111.
2. Single grant: ADDRESS=16'h0101, i_h[LOCAL]=1, i_data[LOCAL]=16'h0201.
   - o_ack_h=5'b10000 exactly 4 cycles after sampling.
   - Then o_mux_in[EAST]=4, o_mux_out[LOCAL]=0, o_free[EAST]=0.
3. All XY directions from ADDRESS=16'h0101: dests 0201/0001/0100/0102/0101 -> outputs EAST/WEST/SOUTH/NORTH/LOCAL respectively.
4. Contention: i_h[EAST]=i_h[WEST]=1, both dest 16'h0101, i_sender[EAST] held 1.
   - EAST acked first.
   - WEST cycles through S_CHECK without ack.
   - Drop i_sender[EAST]: o_free[LOCAL]=1 next cycle, then WEST acked and o_mux_in[LOCAL]=1.
5. Round-robin fairness: i_h=5'b11111 held, every packet to a distinct free port, each acked source releases immediately -> ack order 0,1,2,3,4,0.
6. Reset mid-operation: i_rst=1 during S_GRANT -> o_ack_h=0 next cycle, no table update, all outputs at reset values.

Source files
------------

// File: rtl/switch_control_pkg.sv
// Shared constants, FSM encoding and XY routing helper for the router allocation stage.
package switch_control_pkg;

   localparam int TAM_FLIT   = 16;
   localparam int METADEFLIT = 8;
   localparam int NPORT      = 5;

   localparam logic [2:0] EAST      = 3'd0;
   localparam logic [2:0] WEST      = 3'd1;
   localparam logic [2:0] NORTH     = 3'd2;
   localparam logic [2:0] SOUTH     = 3'd3;
   localparam logic [2:0] LOCAL     = 3'd4;
   localparam logic [2:0] PORT_NONE = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARB   = 3'd1,
      S_ROUTE = 3'd2,
      S_CHECK = 3'd3,
      S_GRANT = 3'd4
   } state_t;

   // X is resolved before Y; equal coordinates deliver to the local port.
   function automatic logic [2:0] xy_route(input logic [TAM_FLIT-1:0] local_addr,
                                           input logic [TAM_FLIT-1:0] dest_addr);
      logic [METADEFLIT-1:0] lx, ly, dx, dy;
      lx = local_addr[TAM_FLIT-1:METADEFLIT];
      ly = local_addr[METADEFLIT-1:0];
      dx = dest_addr[TAM_FLIT-1:METADEFLIT];
      dy = dest_addr[METADEFLIT-1:0];
      if (dx > lx)      return EAST;
      else if (dx < lx) return WEST;
      else if (dy < ly) return SOUTH;
      else if (dy > ly) return NORTH;
      else              return LOCAL;
   endfunction

endpackage

// File: rtl/switch_control_rr_arbiter5.sv
// Combinational five-way round-robin picker: first request found after i_ptr, with wrap.
module rr_arbiter5
   import switch_control_pkg::*;
(
   input  logic [NPORT-1:0] i_req,
   input  logic [2:0]       i_ptr,
   output logic [2:0]       o_grant,
   output logic             o_valid
);

   logic [2:0] w_idx;

   // Scan farthest offset first so the nearest requester overwrites and wins.
   always_comb begin
      o_grant = '0;
      o_valid = 1'b0;
      w_idx   = '0;
      for (int i = NPORT - 1; i >= 0; i--) begin
         w_idx = 3'((int'(i_ptr) + 1 + i) % NPORT);
         if (i_req[w_idx]) begin
            o_grant = w_idx;
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_control.sv
// Router allocation stage: arbitrates header requests, routes XY, books crossbar paths and frees them.
module switch_control
   import switch_control_pkg::*;
#(
   parameter logic [TAM_FLIT-1:0] ADDRESS = 16'h0000
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NPORT-1:0]          i_h,
   input  logic [NPORT*TAM_FLIT-1:0] i_data,
   input  logic [NPORT-1:0]          i_sender,
   output logic [NPORT-1:0]          o_ack_h,
   output logic [NPORT*3-1:0]        o_mux_in,
   output logic [NPORT*3-1:0]        o_mux_out,
   output logic [NPORT-1:0]          o_free
);

   state_t r_state, w_state_next;
   logic [2:0] r_rr_ptr, r_sel, r_route;
   logic [NPORT-1:0] r_free, w_free_next, w_rel;
   logic [2:0] r_mux_in [NPORT];
   logic [2:0] r_mux_out [NPORT];
   logic [2:0] w_mux_in_next [NPORT];
   logic [2:0] w_mux_out_next [NPORT];
   logic [TAM_FLIT-1:0] w_flit [NPORT];
   logic [2:0] w_arb_grant;
   logic       w_arb_valid;

   rr_arbiter5 u_arb (
      .i_req   (i_h),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_arb_grant),
      .o_valid (w_arb_valid)
   );

   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
         assign w_flit[gi]              = i_data[gi*TAM_FLIT +: TAM_FLIT];
         assign o_mux_in[gi*3 +: 3]     = r_mux_in[gi];
         assign o_mux_out[gi*3 +: 3]    = r_mux_out[gi];
         assign w_rel[gi]               = !r_free[gi] && !i_sender[r_mux_in[gi]];
      end
   endgenerate

   assign o_free = r_free;

   always_comb begin
      o_ack_h = '0;
      if (r_state == S_GRANT) o_ack_h[r_sel] = 1'b1;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (|i_h) w_state_next = S_ARB;
         S_ARB:   w_state_next = w_arb_valid ? S_ROUTE : S_IDLE;
         S_ROUTE: w_state_next = S_CHECK;
         S_CHECK: w_state_next = r_free[r_route] ? S_GRANT : S_IDLE;
         S_GRANT: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Release first, then the grant; a grant overrides a release of the same source's old entry.
   always_comb begin
      w_free_next    = r_free | w_rel;
      w_mux_in_next  = r_mux_in;
      w_mux_out_next = r_mux_out;
      for (int q = 0; q < NPORT; q++) begin
         if (w_rel[q]) w_mux_out_next[r_mux_in[q]] = PORT_NONE;
      end
      if (r_state == S_GRANT) begin
         w_mux_in_next[r_route] = r_sel;
         w_mux_out_next[r_sel]  = r_route;
         w_free_next[r_route]   = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= LOCAL;
         r_sel    <= '0;
         r_route  <= '0;
         r_free   <= '1;
         for (int p = 0; p < NPORT; p++) begin
            r_mux_in[p]  <= '0;
            r_mux_out[p] <= PORT_NONE;
         end
      end else begin
         r_state   <= w_state_next;
         r_free    <= w_free_next;
         r_mux_in  <= w_mux_in_next;
         r_mux_out <= w_mux_out_next;
         if (r_state == S_ARB && w_arb_valid) begin
            r_sel    <= w_arb_grant;
            r_rr_ptr <= w_arb_grant;
         end
         if (r_state == S_ROUTE) r_route <= xy_route(ADDRESS, w_flit[r_sel]);
      end
   end

endmodule

// File: tb/tb_switch_control.sv
// Directed self-checking bench for switch_control with router address 0x0101.
module tb_switch_control;
   import switch_control_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  h, sender;
   logic [79:0] data;
   logic [4:0]  ack, free;
   logic [14:0] mux_in, mux_out;
   int          ntests = 0;
   int          nfail  = 0;

   always #5 clk = ~clk;

   switch_control #(.ADDRESS(16'h0101)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_h       (h),
      .i_data    (data),
      .i_sender  (sender),
      .o_ack_h   (ack),
      .o_mux_in  (mux_in),
      .o_mux_out (mux_out),
      .o_free    (free)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input string tag, input int bound);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < bound && !seen; c++) begin
         step();
         if (ack != 5'b0) seen = 1'b1;
      end
      chk({tag, " ack within bound"}, 32'(seen), 32'd1);
   endtask

   // Full header lifecycle from one source: exact 4-cycle latency, table update, release.
   task automatic single(input string tag, input int src, input logic [15:0] dest, input int out);
      h[src] = 1'b1;
      data[src*16 +: 16] = dest;
      sender[src] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk({tag, " no early ack"}, 32'(ack), 32'd0);
      end
      step();
      chk({tag, " ack"}, 32'(ack), 32'(5'd1 << src));
      h[src] = 1'b0;
      step();
      chk({tag, " ack one cycle"}, 32'(ack), 32'd0);
      chk({tag, " mux_in"}, 32'(mux_in[out*3 +: 3]), 32'(src));
      chk({tag, " mux_out"}, 32'(mux_out[src*3 +: 3]), 32'(out));
      chk({tag, " busy"}, 32'(free), 32'(5'h1f & ~(5'd1 << out)));
      sender[src] = 1'b0;
      step();
      chk({tag, " released"}, 32'(free), 32'h1f);
      chk({tag, " mux_out cleared"}, 32'(mux_out[src*3 +: 3]), 32'd7);
      chk({tag, " mux_in kept"}, 32'(mux_in[out*3 +: 3]), 32'(src));
   endtask

   logic [15:0] dests [5];
   int          outs  [5];

   initial begin
      rst = 1'b1; h = '0; sender = '0; data = '0;

      // Reset
      step(); step();
      rst = 1'b0;
      chk("reset free", 32'(free), 32'h1f);
      chk("reset ack", 32'(ack), 32'd0);
      chk("reset mux_out", 32'(mux_out), 32'h7fff);
      chk("reset mux_in", 32'(mux_in), 32'd0);

      // Single grant LOCAL -> EAST
      single("single", 4, 16'h0201, 0);

      // All XY directions from the local port
      dests[0] = 16'h0201; outs[0] = 0;
      dests[1] = 16'h0001; outs[1] = 1;
      dests[2] = 16'h0100; outs[2] = 3;
      dests[3] = 16'h0102; outs[3] = 2;
      dests[4] = 16'h0101; outs[4] = 4;
      for (int i = 0; i < 5; i++) single($sformatf("xy%0d", i), 4, dests[i], outs[i]);

      // Contention for LOCAL output: EAST wins, WEST retries until EAST releases
      h = 5'b00011; data[0 +: 16] = 16'h0101; data[16 +: 16] = 16'h0101; sender = 5'b00011;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("cont no early ack", 32'(ack), 32'd0);
      end
      step();
      chk("cont east ack", 32'(ack), 32'd1);
      h[0] = 1'b0;
      for (int c = 0; c < 12; c++) begin
         step();
         chk("cont west blocked", 32'(ack), 32'd0);
      end
      chk("cont local busy", 32'(free[4]), 32'd0);
      chk("cont east path", 32'(mux_out[0 +: 3]), 32'd4);
      sender[0] = 1'b0;
      step();
      chk("cont local freed", 32'(free[4]), 32'd1);
      chk("cont east unhooked", 32'(mux_out[0 +: 3]), 32'd7);
      wait_ack("cont west", 8);
      chk("cont west ack", 32'(ack), 32'd2);
      h = '0;
      step();
      chk("cont mux_in local", 32'(mux_in[12 +: 3]), 32'd1);
      chk("cont mux_out west", 32'(mux_out[3 +: 3]), 32'd4);
      chk("cont local busy again", 32'(free[4]), 32'd0);
      sender = '0;
      step(); step();
      chk("cont all free", 32'(free), 32'h1f);

      // Round-robin fairness from reset pointer
      rst = 1'b1; step(); rst = 1'b0;
      data = {16'h0101, 16'h0100, 16'h0102, 16'h0001, 16'h0201};
      sender = '0;
      h = 5'b11111;
      for (int i = 0; i < 6; i++) begin
         wait_ack($sformatf("rr%0d", i), 8);
         chk($sformatf("rr%0d order", i), 32'(ack), 32'(5'd1 << (i % 5)));
      end
      h = '0;
      step(); step();
      chk("rr all free", 32'(free), 32'h1f);

      // Reset during the grant cycle
      h = 5'b00001; data[0 +: 16] = 16'h0102; sender = 5'b00001;
      step(); step(); step(); step();
      chk("midrst ack", 32'(ack), 32'd1);
      rst = 1'b1;
      step();
      chk("midrst ack cleared", 32'(ack), 32'd0);
      chk("midrst free", 32'(free), 32'h1f);
      chk("midrst mux_out", 32'(mux_out), 32'h7fff);
      chk("midrst mux_in", 32'(mux_in), 32'd0);
      rst = 1'b0; h = '0; sender = '0;
      step();
      chk("midrst no late update", 32'(mux_out), 32'h7fff);
      chk("midrst no late ack", 32'(ack), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
